coin_tile_writer: RTL and testbench

Responder for the per-coin touch signals. It collects touch events from N coin detectors and queues simultaneous events so that none is dropped. For each event it reads the coin's tile, checks that the tile is still a token, then writes SKY through a single tile-map write port. It also keeps sticky collected flags and a saturating score that drives LEDs and the HUD.

---
 rtl/mario_pkg.sv | 27 ++
 rtl/coin_priority_arbiter.sv | 20 ++
 rtl/coin_tile_writer.sv | 138 +++++++++++++
 tb/tb_coin_tile_writer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared Mario game package.
// Tile codes, screen geometry and tile-writer types.
package mario_pkg;

  localparam int BDR = 0;
  localparam int SKY = 1;
  localparam int BLK = 2;
  localparam int GND = 3;
  localparam int TKN = 4;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BLOCK_WIDTH   = 40;
  localparam int MARIO_WIDTH   = 32;

  typedef logic [7:0] tile_t;
  typedef logic [3:0] row_t;
  typedef logic [4:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    WRITE
  } writer_state_t;

endpackage

// File: rtl/coin_priority_arbiter.sv
// Fixed-priority arbiter.
// The lowest set request bit wins.
module coin_priority_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = IW'(i);
    end
  end

endmodule

// File: rtl/coin_tile_writer.sv
// Coin touch responder.
// Queues touch events, clears token tiles to SKY and keeps the score.
module coin_tile_writer
  import mario_pkg::*;
#(
  parameter int NUM_COINS = 2,
  parameter int ROWS      = 12,
  parameter int COLS      = 17,
  parameter int ROW_W     = 4,
  parameter int COL_W     = 5,
  parameter int SKY       = mario_pkg::SKY,
  parameter int TKN       = mario_pkg::TKN,
  parameter int SCORE_W   = 10
) (
  input  logic                             vga_clock,
  input  logic                             reset,
  input  logic [NUM_COINS-1:0]             touch,
  input  logic [NUM_COINS-1:0][ROW_W-1:0]  coin_row,
  input  logic [NUM_COINS-1:0][COL_W-1:0]  coin_col,
  output logic [ROW_W-1:0]                 rd_row,
  output logic [COL_W-1:0]                 rd_col,
  input  logic [7:0]                       rd_data,
  output logic                             wr_en,
  output logic [ROW_W-1:0]                 wr_row,
  output logic [COL_W-1:0]                 wr_col,
  output logic [7:0]                       wr_data,
  output logic [NUM_COINS-1:0]             collected,
  output logic [SCORE_W-1:0]               score,
  output logic                             busy,
  output logic                             all_collected
);

  localparam int IW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

  if (ROWS > (1 << ROW_W) || COLS > (1 << COL_W)) begin : g_bad_dims
    $error("tile-map dimensions exceed index widths");
  end

  writer_state_t          r_state, w_state_n;
  logic [NUM_COINS-1:0]   r_pend, r_coll, r_touch_q;
  logic [SCORE_W-1:0]     r_score;
  logic [IW-1:0]          r_idx;
  logic [ROW_W-1:0]       r_rd_row, r_wr_row;
  logic [COL_W-1:0]       r_rd_col, r_wr_col;

  logic [NUM_COINS-1:0]   w_rise, w_clr;
  logic                   w_gv, w_grant, w_load_wr, w_mark, w_inc;
  logic [IW-1:0]          w_gi;

  assign w_rise = touch & ~r_touch_q;

  coin_priority_arbiter #(
    .N  (NUM_COINS),
    .IW (IW)
  ) u_arb (
    .req         (r_pend),
    .grant_valid (w_gv),
    .grant_idx   (w_gi)
  );

  always_comb begin
    w_state_n = r_state;
    w_grant   = 1'b0;
    w_load_wr = 1'b0;
    w_mark    = 1'b0;
    w_inc     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_gv) begin
          w_grant   = 1'b1;
          w_state_n = READ;
        end
      end
      READ: w_state_n = CHECK;
      CHECK: begin
        if (rd_data == 8'(TKN)) begin
          w_load_wr = 1'b1;
          w_state_n = WRITE;
        end else begin
          // Tile already cleared elsewhere: retire the coin, no score.
          w_mark    = 1'b1;
          w_state_n = IDLE;
        end
      end
      WRITE: begin
        w_mark    = 1'b1;
        w_inc     = 1'b1;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Grant clear wins over a same-cycle rise on the granted index.
  assign w_clr = w_grant ? (NUM_COINS'(1) << w_gi) : '0;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pend    <= '0;
      r_coll    <= '0;
      r_touch_q <= '0;
      r_score   <= '0;
      r_idx     <= '0;
      r_rd_row  <= '0;
      r_rd_col  <= '0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_touch_q <= touch;
      r_pend    <= (r_pend | (w_rise & ~r_coll)) & ~w_clr;
      if (w_grant) begin
        r_idx    <= w_gi;
        r_rd_row <= coin_row[w_gi];
        r_rd_col <= coin_col[w_gi];
      end
      if (w_load_wr) begin
        r_wr_row <= r_rd_row;
        r_wr_col <= r_rd_col;
      end
      if (w_mark) r_coll[r_idx] <= 1'b1;
      if (w_inc && r_score != '1) r_score <= r_score + 1'b1;
    end
  end

  assign rd_row        = r_rd_row;
  assign rd_col        = r_rd_col;
  assign wr_en         = (r_state == WRITE);
  assign wr_row        = r_wr_row;
  assign wr_col        = r_wr_col;
  assign wr_data       = 8'(SKY);
  assign collected     = r_coll;
  assign score         = r_score;
  assign busy          = (r_state != IDLE) || (|r_pend);
  assign all_collected = &r_coll;

endmodule

// File: tb/tb_coin_tile_writer.sv
// Directed bench for coin_tile_writer.
// Tile map is modelled with a one-cycle registered read.
module tb_coin_tile_writer;

  logic             vga_clock = 1'b0;
  logic             reset     = 1'b0;
  logic [1:0]       touch     = '0;
  logic [1:0][3:0]  coin_row;
  logic [1:0][4:0]  coin_col;
  logic [3:0]       rd_row;
  logic [4:0]       rd_col;
  logic [7:0]       rd_data   = '0;
  logic             wr_en;
  logic [3:0]       wr_row;
  logic [4:0]       wr_col;
  logic [7:0]       wr_data;
  logic [1:0]       collected;
  logic [9:0]       score;
  logic             busy;
  logic             all_collected;

  logic [7:0] map [12][17];
  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  always #5 vga_clock = ~vga_clock;

  always @(posedge vga_clock) begin
    rd_data <= map[rd_row][rd_col];
    if (wr_en) map[wr_row][wr_col] <= wr_data;
  end

  coin_tile_writer dut (
    .vga_clock     (vga_clock),
    .reset         (reset),
    .touch         (touch),
    .coin_row      (coin_row),
    .coin_col      (coin_col),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_data       (wr_data),
    .collected     (collected),
    .score         (score),
    .busy          (busy),
    .all_collected (all_collected)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clock);
    #1;
    if (wr_en) wr_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    touch = '0;
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    tick();
    wr_cnt = 0;
  endtask

  initial begin
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        map[r][c] = 8'd3;
    coin_row[0] = 4'd6;
    coin_col[0] = 5'd6;
    coin_row[1] = 4'd1;
    coin_col[1] = 5'd15;

    // Reset state
    ticks(2);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_data", 32'(wr_data), 1);
    check("rst_score", 32'(score), 0);
    check("rst_coll", 32'(collected), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_row", 32'(rd_row), 0);
    check("rst_all", 32'(all_collected), 0);
    reset = 1'b1;
    tick();

    // Single coin collection
    map[6][6] = 8'd4;
    map[1][15] = 8'd4;
    wr_cnt = 0;
    touch = 2'b01;
    tick();
    check("t1_busy", 32'(busy), 1);
    ticks(2);
    check("t1_no_wr_c3", 32'(wr_en), 0);
    tick();
    check("t1_wr_en_c4", 32'(wr_en), 1);
    check("t1_wr_row", 32'(wr_row), 6);
    check("t1_wr_col", 32'(wr_col), 6);
    check("t1_wr_data", 32'(wr_data), 1);
    tick();
    check("t1_wr_off", 32'(wr_en), 0);
    check("t1_coll", 32'(collected), 32'b01);
    check("t1_score", 32'(score), 1);
    check("t1_busy_done", 32'(busy), 0);
    check("t1_map", 32'(map[6][6]), 1);

    // Simultaneous rises on both coins
    do_reset();
    map[6][6] = 8'd4;
    map[1][15] = 8'd4;
    touch = 2'b11;
    ticks(4);
    check("t2_wr1", 32'(wr_en), 1);
    check("t2_row1", 32'(wr_row), 6);
    check("t2_col1", 32'(wr_col), 6);
    ticks(3);
    check("t2_gap", 32'(wr_en), 0);
    tick();
    check("t2_wr2", 32'(wr_en), 1);
    check("t2_row2", 32'(wr_row), 1);
    check("t2_col2", 32'(wr_col), 15);
    tick();
    check("t2_coll", 32'(collected), 32'b11);
    check("t2_all", 32'(all_collected), 1);
    check("t2_score", 32'(score), 2);
    check("t2_wr_cnt", 32'(wr_cnt), 2);

    // Held touch and re-touch after collection
    do_reset();
    map[6][6] = 8'd4;
    touch = 2'b01;
    ticks(50);
    touch = 2'b00;
    ticks(3);
    touch = 2'b01;
    ticks(10);
    touch = 2'b00;
    ticks(3);
    check("t3_wr_cnt", 32'(wr_cnt), 1);
    check("t3_score", 32'(score), 1);
    check("t3_coll", 32'(collected), 32'b01);

    // Tile already SKY
    do_reset();
    map[1][15] = 8'd1;
    touch = 2'b10;
    ticks(10);
    check("t4_wr_cnt", 32'(wr_cnt), 0);
    check("t4_coll", 32'(collected), 32'b10);
    check("t4_score", 32'(score), 0);
    check("t4_busy", 32'(busy), 0);

    // Reset during READ
    do_reset();
    map[6][6] = 8'd4;
    touch = 2'b01;
    ticks(2);
    check("t5_busy_read", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("t5_rst_wr_en", 32'(wr_en), 0);
    check("t5_rst_rd_row", 32'(rd_row), 0);
    check("t5_rst_busy", 32'(busy), 0);
    touch = 2'b00;
    ticks(2);
    reset = 1'b1;
    ticks(6);
    check("t5_no_wr", 32'(wr_cnt), 0);
    check("t5_map_kept", 32'(map[6][6]), 4);
    touch = 2'b01;
    ticks(3);
    check("t5_fresh_c3", 32'(wr_en), 0);
    tick();
    check("t5_fresh_c4", 32'(wr_en), 1);
    tick();
    check("t5_score", 32'(score), 1);

    // Score saturation
    do_reset();
    map[6][6] = 8'd4;
    force dut.r_score = 10'd1023;
    tick();
    release dut.r_score;
    tick();
    check("t6_forced", 32'(score), 1023);
    touch = 2'b01;
    ticks(4);
    check("t6_wr_en", 32'(wr_en), 1);
    tick();
    check("t6_score_sat", 32'(score), 1023);
    check("t6_coll", 32'(collected), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
